ped_request_ctrl: RTL and testbench

Pedestrian-request front end for the intersection traffic controller. It sits directly upstream of the controller: it synchronises and debounces the raw crosswalk push-button, then latches a request. It holds `ped_req` to the controller until the controller opens a walk phase, and then enforces a post-walk cooldown. It also drives the "WAIT" indicator lamp and an urgency flag for requests that have been pending too long.

---
 rtl/traffic_pkg.sv | 19 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/ped_request_ctrl.sv | 158 +++++++++++++++
 tb/tb_ped_request_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and default constants for the pedestrian request path
//
// Purpose: FSM state encoding and default timing constants used by
// ped_request_ctrl and btn_debounce.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    SERVED   = 2'd2,
    COOLDOWN = 2'd3
  } ped_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_COOLDOWN_CYCLES = 200;
  localparam int DEF_MAX_WAIT        = 1000;
  localparam int DEF_WAIT_W          = 16;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, stability debouncer and rising-edge pulse
//
// Purpose: accept a raw asynchronous button, synchronise it, change the
// debounced level only after DEBOUNCE_CYCLES consecutive differing samples,
// and emit a registered one-cycle pulse on each debounced rising edge.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset (level returns to 0)
//   btn    in  raw asynchronous button, active-high
//   press  out one-cycle pulse per debounced rising edge
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // cnt counts consecutive samples that disagree with the current level;
      // any agreeing sample restarts the count, so short glitches are dropped.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          press <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian request latch, walk handshake and cooldown FSM
//
// Purpose: debounces the crosswalk button, latches a request and holds
// ped_req until the controller opens a walk phase, then enforces a post-walk
// cooldown. Drives the WAIT lamp and an urgency flag.
// Build option: define PED_URGENT_EN to build the wait counter and ped_urgent
// compare; otherwise ped_urgent is tied to 0.
// Ports:
//   clk          in  system clock
//   reset        in  synchronous active-high reset
//   btn          in  raw crosswalk push-button
//   maint        in  maintenance mode level, forces IDLE and clears requests
//   walk_active  in  controller walk-green indication
//   ped_req      out request to the controller
//   wait_lamp    out WAIT indicator
//   ped_urgent   out request pending MAX_WAIT cycles or more
//   served_cnt   out walk phases that served a request, wraps at 255
module ped_request_ctrl
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int MAX_WAIT        = DEF_MAX_WAIT,
  parameter int WAIT_W          = DEF_WAIT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       maint,
  input  logic       walk_active,
  output logic       ped_req,
  output logic       wait_lamp,
  output logic       ped_urgent,
  output logic [7:0] served_cnt
);

  localparam logic [WAIT_W-1:0] COOL_LOAD = WAIT_W'(COOLDOWN_CYCLES - 1);

  ped_state_t        state, next_state;
  logic              pend_flag, pend_next;
  logic [WAIT_W-1:0] cool_cnt, cool_next;
  logic [7:0]        served_next;
  logic              press;
  logic              walk_q, walk_q_d;
  logic              walk_rise, walk_fall;
  logic              req_next, lamp_next, urg_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .press(press)
  );

  assign walk_rise = walk_q & ~walk_q_d;
  assign walk_fall = ~walk_q & walk_q_d;

  always_comb begin
    next_state  = state;
    pend_next   = pend_flag;
    cool_next   = cool_cnt;
    served_next = served_cnt;
    if (maint) begin
      next_state = IDLE;
      pend_next  = 1'b0;
      cool_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (walk_rise)  next_state = SERVED;
          else if (press) next_state = PENDING;
        end
        PENDING: begin
          if (walk_rise) begin
            next_state  = SERVED;
            served_next = served_cnt + 8'd1;
          end
        end
        SERVED: begin
          if (walk_fall) begin
            next_state = COOLDOWN;
            cool_next  = COOL_LOAD;
          end
        end
        COOLDOWN: begin
          if (walk_rise) begin
            // Controller served the crossing early; only count it if someone
            // was actually waiting.
            next_state = SERVED;
            pend_next  = 1'b0;
            if (pend_flag) served_next = served_cnt + 8'd1;
          end else if (cool_cnt == '0) begin
            pend_next  = 1'b0;
            next_state = (pend_flag || press) ? PENDING : IDLE;
          end else begin
            cool_next = cool_cnt - WAIT_W'(1);
            if (press) pend_next = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so they switch on the same
  // edge as the state register.
  assign req_next  = (next_state == PENDING);
  assign lamp_next = (next_state == PENDING) || ((next_state == COOLDOWN) && pend_next);

`ifdef PED_URGENT_EN
  logic [WAIT_W-1:0] wait_cnt, wait_next;

  always_comb begin
    wait_next = wait_cnt;
    if (maint || ((next_state == PENDING) && (state != PENDING))) begin
      wait_next = '0;
    end else if ((state == PENDING) && (wait_cnt != '1)) begin
      wait_next = wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt <= '0;
    else       wait_cnt <= wait_next;
  end

  assign urg_next = (next_state == PENDING) && (wait_next >= WAIT_W'(MAX_WAIT));
`else
  assign urg_next = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_flag  <= 1'b0;
      cool_cnt   <= '0;
      served_cnt <= '0;
      walk_q     <= 1'b0;
      walk_q_d   <= 1'b0;
      ped_req    <= 1'b0;
      wait_lamp  <= 1'b0;
      ped_urgent <= 1'b0;
    end else begin
      state      <= next_state;
      pend_flag  <= pend_next;
      cool_cnt   <= cool_next;
      served_cnt <= served_next;
      walk_q     <= walk_active;
      walk_q_d   <= walk_q;
      ped_req    <= req_next;
      wait_lamp  <= lamp_next;
      ped_urgent <= urg_next;
    end
  end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb/tb_ped_request_ctrl.sv - scoreboard bench for ped_request_ctrl
module tb_ped_request_ctrl;

  logic       clk;
  logic       reset;
  logic       btn;
  logic       maint;
  logic       walk_active;
  logic       ped_req;
  logic       wait_lamp;
  logic       ped_urgent;
  logic [7:0] served_cnt;

`ifdef PED_URGENT_EN
  localparam logic URG = 1'b1;
`else
  localparam logic URG = 1'b0;
`endif

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .COOLDOWN_CYCLES(200),
    .MAX_WAIT       (1000),
    .WAIT_W         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .maint      (maint),
    .walk_active(walk_active),
    .ped_req    (ped_req),
    .wait_lamp  (wait_lamp),
    .ped_urgent (ped_urgent),
    .served_cnt (served_cnt)
  );

  typedef struct {
    int          cyc;
    logic [10:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic expect_at(input int c, input string nm, input logic rq, input logic lp,
                           input logic ug, input logic [7:0] sc);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.val  = {rq, lp, ug, sc};
    sb.push_back(e);
  endtask

  // Monitor: sample away from the active edge and retire every expectation due now.
  always @(negedge clk) begin
    exp_t        e;
    logic [10:0] act;
    act = {ped_req, wait_lamp, ped_urgent, served_cnt};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s @%0d: got req=%b lamp=%b urg=%b served=%0d, want req=%b lamp=%b urg=%b served=%0d",
                 e.name, cyc, act[10], act[9], act[8], act[7:0],
                 e.val[10], e.val[9], e.val[8], e.val[7:0]);
      end
    end
  end

  initial begin
    int         t0;
    int         tf;
    logic [7:0] s;

    reset = 1'b1; btn = 1'b0; maint = 1'b0; walk_active = 1'b0;
    tick(3);
    reset = 1'b0;
    expect_at(cyc, "reset_state", 0, 0, 0, 8'd0);
    tick(2);

    // Held press: request 19 cycles after the button change.
    t0 = cyc; btn = 1'b1;
    expect_at(t0 + 18, "press_pre", 0, 0, 0, 8'd0);
    expect_at(t0 + 19, "press_req", 1, 1, 0, 8'd0);
    tick(30); btn = 1'b0;

    // Walk serves the request: ped_req falls 2 cycles later.
    t0 = cyc; walk_active = 1'b1;
    expect_at(t0 + 1, "walk_hold", 1, 1, 0, 8'd0);
    expect_at(t0 + 2, "walk_served", 0, 0, 0, 8'd1);
    tick(5); walk_active = 1'b0;
    tick(210);

    // Second request, serve, then press during cooldown.
    t0 = cyc; btn = 1'b1;
    expect_at(t0 + 19, "press2_req", 1, 1, 0, 8'd1);
    tick(25); btn = 1'b0; tick(5);
    t0 = cyc; walk_active = 1'b1;
    expect_at(t0 + 2, "walk2_served", 0, 0, 0, 8'd2);
    tick(3); walk_active = 1'b0; tf = cyc;
    tick(20);
    t0 = cyc; btn = 1'b1;
    expect_at(t0 + 18, "cool_press_pre", 0, 0, 0, 8'd2);
    expect_at(t0 + 19, "cool_press_lamp", 0, 1, 0, 8'd2);
    expect_at(tf + 201, "cool_last", 0, 1, 0, 8'd2);
    expect_at(tf + 202, "cool_expire_req", 1, 1, 0, 8'd2);
    expect_at(tf + 202 + 999, "urgent_pre", 1, 1, 0, 8'd2);
    expect_at(tf + 202 + 1000, "urgent_rise", 1, 1, URG, 8'd2);
    tick(25); btn = 1'b0;
    tick_to(tf + 202 + 1005);

    // Maintenance pulse while pending.
    t0 = cyc; maint = 1'b1;
    expect_at(t0, "maint_pre", 1, 1, URG, 8'd2);
    expect_at(t0 + 1, "maint_force", 0, 0, 0, 8'd2);
    tick(5); maint = 1'b0;
    expect_at(t0 + 5, "maint_end", 0, 0, 0, 8'd2);
    expect_at(t0 + 30, "maint_no_resume", 0, 0, 0, 8'd2);
    tick(35);

    // Glitch shorter than the debounce window.
    t0 = cyc; btn = 1'b1;
    tick(10); btn = 1'b0;
    expect_at(t0 + 19, "glitch_19", 0, 0, 0, 8'd2);
    expect_at(t0 + 40, "glitch_40", 0, 0, 0, 8'd2);
    tick(45);

    // Walk from IDLE: no count, enters cooldown afterwards.
    t0 = cyc; walk_active = 1'b1;
    expect_at(t0 + 2, "idle_walk", 0, 0, 0, 8'd2);
    tick(4); walk_active = 1'b0; tick(4);

    // Press in cooldown then early walk: served_cnt wraps after 256 serves.
    s = 8'd2;
    for (int i = 0; i < 254; i++) begin
      t0 = cyc; btn = 1'b1;
      expect_at(t0 + 19, "loop_lamp", 0, 1, 0, s);
      tick(20); btn = 1'b0; tick(20);
      t0 = cyc; walk_active = 1'b1; s = s + 8'd1;
      expect_at(t0 + 2, "loop_served", 0, 0, 0, s);
      tick(4); walk_active = 1'b0; tick(4);
    end

    // Reset in the middle of a pending request.
    tick(220);
    t0 = cyc; btn = 1'b1;
    expect_at(t0 + 19, "rst_pending", 1, 1, 0, 8'd0);
    tick(25);
    reset = 1'b1; btn = 1'b0;
    expect_at(cyc + 1, "rst_clear", 0, 0, 0, 8'd0);
    tick(2); reset = 1'b0;
    expect_at(cyc + 30, "post_rst_idle", 0, 0, 0, 8'd0);
    tick(35);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked, required at cycle %0d, run ended at %0d", e.name, e.cyc, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
